// File: rtl/bsg_imul_pkg.sv
// Shared types for the multiply dispatch front end: RISC-V M-ext funct codes,
// dispatch FSM states and the decoded multiplier control bundle.
package bsg_imul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } funct_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic signed_a;
        logic signed_b;
        logic gets_high;
    } mul_ctrl_s;

    function automatic mul_ctrl_s decode_funct(input funct_e funct);
        mul_ctrl_s ctrl;
        ctrl = '0;
        unique case (funct)
            MUL:    ctrl = '{signed_a: 1'b0, signed_b: 1'b0, gets_high: 1'b0};
            MULH:   ctrl = '{signed_a: 1'b1, signed_b: 1'b1, gets_high: 1'b1};
            MULHSU: ctrl = '{signed_a: 1'b1, signed_b: 1'b0, gets_high: 1'b1};
            MULHU:  ctrl = '{signed_a: 1'b0, signed_b: 1'b0, gets_high: 1'b1};
            default: ctrl = '0;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/bsg_imul_req_fifo.sv
// Request FIFO for the multiply dispatcher. Head is read straight from storage,
// so an entry written at cycle t is visible at t+1; no enq/deq bypass when full.
module bsg_imul_req_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         enq_v_i,
    input  logic [width_p-1:0]           enq_data_i,
    input  logic                         deq_i,
    output logic [width_p-1:0]           deq_data_o,
    output logic [$clog2(els_p+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int ptr_width_lp   = $clog2(els_p);
    localparam int count_width_lp = $clog2(els_p+1);

    logic [width_p-1:0]        mem_q [els_p];
    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic                      enq, deq;

    function automatic logic [ptr_width_lp-1:0] bump(input logic [ptr_width_lp-1:0] ptr);
        return (ptr == ptr_width_lp'(els_p-1)) ? '0 : ptr + ptr_width_lp'(1);
    endfunction

    assign full_o     = (count_q == count_width_lp'(els_p));
    assign empty_o    = (count_q == '0);
    assign enq        = enq_v_i & ~full_o;
    assign deq        = deq_i & ~empty_o;
    assign count_o    = count_q;
    assign deq_data_o = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = deq ? bump(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = enq ? bump(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + count_width_lp'(enq) - count_width_lp'(deq);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < els_p; gi++) begin : g_mem
        always_ff @(posedge clk_i) begin
            if (enq && (wr_ptr_q == ptr_width_lp'(gi))) begin
                mem_q[gi] <= enq_data_i;
            end
        end
    end

endmodule

// File: rtl/bsg_imul_dispatch.sv
// Multiply dispatch front end: buffers tagged M-ext requests, issues them one at a
// time to an iterative multiplier and returns results in order on a valid/yumi port.
module bsg_imul_dispatch
    import bsg_imul_pkg::*;
#(
    parameter int width_p     = 32,
    parameter int tag_width_p = 4,
    parameter int els_p       = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    output logic                   ready_and_o,
    input  logic [1:0]             funct_i,
    input  logic [width_p-1:0]     opA_i,
    input  logic [width_p-1:0]     opB_i,
    input  logic [tag_width_p-1:0] tag_i,
    output logic                   mul_v_o,
    input  logic                   mul_ready_and_i,
    output logic [width_p-1:0]     mul_opA_o,
    output logic [width_p-1:0]     mul_opB_o,
    output logic                   mul_signed_opA_o,
    output logic                   mul_signed_opB_o,
    output logic                   mul_gets_high_part_o,
    input  logic                   mul_v_i,
    input  logic [width_p-1:0]     mul_result_i,
    output logic                   mul_yumi_o,
    output logic                   v_o,
    output logic [width_p-1:0]     result_o,
    output logic [tag_width_p-1:0] tag_o,
    input  logic                   yumi_i
);

    localparam int req_width_lp   = 2 + 2*width_p + tag_width_p;
    localparam int count_width_lp = $clog2(els_p+1);

    logic [req_width_lp-1:0]   enq_data, head_data;
    logic [count_width_lp-1:0] fifo_count;
    logic                      fifo_full, fifo_empty, deq;
    logic                      count_unused;
    logic [1:0]                head_funct;
    logic [width_p-1:0]        head_a, head_b;
    logic [tag_width_p-1:0]    head_tag;
    mul_ctrl_s                 head_ctrl;

    state_e                 state_q, state_d;
    logic [width_p-1:0]     result_q, result_d;
    logic [tag_width_p-1:0] tag_q, tag_d;
    logic [tag_width_p-1:0] inflight_tag_q, inflight_tag_d;

    assign enq_data = {funct_i, opA_i, opB_i, tag_i};

    bsg_imul_req_fifo #(
        .width_p (req_width_lp),
        .els_p   (els_p)
    ) req_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .enq_v_i    (v_i),
        .enq_data_i (enq_data),
        .deq_i      (deq),
        .deq_data_o (head_data),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign count_unused = ^fifo_count;
    assign {head_funct, head_a, head_b, head_tag} = head_data;
    assign head_ctrl = decode_funct(funct_e'(head_funct));

    assign ready_and_o          = ~fifo_full;
    assign mul_opA_o            = head_a;
    assign mul_opB_o            = head_b;
    assign mul_signed_opA_o     = head_ctrl.signed_a;
    assign mul_signed_opB_o     = head_ctrl.signed_b;
    assign mul_gets_high_part_o = head_ctrl.gets_high;
    assign v_o                  = (state_q == HOLD);
    assign result_o             = result_q;
    assign tag_o                = tag_q;

    always_comb begin
        state_d        = state_q;
        result_d       = result_q;
        tag_d          = tag_q;
        inflight_tag_d = inflight_tag_q;
        deq            = 1'b0;
        mul_v_o        = 1'b0;
        mul_yumi_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    // A zero operand makes every product half zero, so skip the multiplier.
                    if ((head_a == '0) || (head_b == '0)) begin
                        deq      = 1'b1;
                        result_d = '0;
                        tag_d    = head_tag;
                        state_d  = HOLD;
                    end else begin
                        mul_v_o = 1'b1;
                        if (mul_ready_and_i) begin
                            deq            = 1'b1;
                            inflight_tag_d = head_tag;
                            state_d        = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                mul_yumi_o = mul_v_i;
                if (mul_v_i) begin
                    result_d = mul_result_i;
                    tag_d    = inflight_tag_q;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q        <= IDLE;
            result_q       <= '0;
            tag_q          <= '0;
            inflight_tag_q <= '0;
        end else begin
            state_q        <= state_d;
            result_q       <= result_d;
            tag_q          <= tag_d;
            inflight_tag_q <= inflight_tag_d;
        end
    end

`ifdef FORMAL
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!v_o || (state_q == HOLD));
            assert (fifo_count <= count_width_lp'(els_p));
            assert (!mul_v_o || ((state_q == IDLE) && !fifo_empty));
        end
    end
`endif

endmodule

// File: tb/tb_bsg_imul_dispatch.sv
// Scoreboard bench for bsg_imul_dispatch with a behavioural multiplier of random latency.
module tb_bsg_imul_dispatch;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i;
    logic        ready_and_o;
    logic [1:0]  funct_i;
    logic [31:0] opA_i, opB_i;
    logic [3:0]  tag_i;
    logic        mul_v_o;
    logic        mul_ready_and_i;
    logic [31:0] mul_opA_o, mul_opB_o;
    logic        mul_signed_opA_o, mul_signed_opB_o, mul_gets_high_part_o;
    logic        mul_v_i;
    logic [31:0] mul_result_i;
    logic        mul_yumi_o;
    logic        v_o;
    logic [31:0] result_o;
    logic [3:0]  tag_o;
    logic        yumi_i;

    always #5 clk_i = ~clk_i;

    bsg_imul_dispatch #(.width_p(32), .tag_width_p(4), .els_p(4)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .v_i(v_i), .ready_and_o(ready_and_o), .funct_i(funct_i),
        .opA_i(opA_i), .opB_i(opB_i), .tag_i(tag_i),
        .mul_v_o(mul_v_o), .mul_ready_and_i(mul_ready_and_i),
        .mul_opA_o(mul_opA_o), .mul_opB_o(mul_opB_o),
        .mul_signed_opA_o(mul_signed_opA_o), .mul_signed_opB_o(mul_signed_opB_o),
        .mul_gets_high_part_o(mul_gets_high_part_o),
        .mul_v_i(mul_v_i), .mul_result_i(mul_result_i), .mul_yumi_o(mul_yumi_o),
        .v_o(v_o), .result_o(result_o), .tag_o(tag_o), .yumi_i(yumi_i)
    );

    typedef struct packed { logic [31:0] res; logic [3:0] tag; } exp_t;
    typedef struct packed { logic [31:0] a; logic [31:0] b; logic [2:0] ctrl; } iss_t;

    exp_t sb_q[$];
    iss_t iss_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   yumi_mode = 1;     // 0: hold off, 1: always consume, 2: random
    bit   manual = 1'b0;     // main process drives the multiplier side
    bit   mdl_busy = 1'b0;
    int   mdl_lat = 0;
    logic [31:0] mdl_res = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {signed rs1, signed rs2, high half} for each funct code
    function automatic logic [2:0] ref_ctrl(input logic [1:0] f);
        case (f)
            2'd0:    return 3'b000;
            2'd1:    return 3'b111;
            2'd2:    return 3'b101;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        logic [63:0] p;
        x = (f == 2'd1 || f == 2'd2) ? longint'($signed(a)) : longint'({32'b0, a});
        y = (f == 2'd1) ? longint'($signed(b)) : longint'({32'b0, b});
        p = x * y;
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] hw_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb, input logic hi);
        longint x, y;
        logic [63:0] p;
        x = sa ? longint'($signed(a)) : longint'({32'b0, a});
        y = sb ? longint'($signed(b)) : longint'({32'b0, b});
        p = x * y;
        return hi ? p[63:32] : p[31:0];
    endfunction

    // Called at a negedge; returns at the negedge after acceptance with v_i dropped.
    task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        int n = 0;
        v_i = 1'b1; funct_i = f; opA_i = a; opB_i = b; tag_i = t;
        #1;
        while (!ready_and_o && n < 300) begin
            @(negedge clk_i); #1; n++;
        end
        check("send_ready", ready_and_o, 1);
        if (ready_and_o) begin
            sb_q.push_back({ref_mul(f, a, b), t});
            if (a != 0 && b != 0) iss_q.push_back({a, b, ref_ctrl(f)});
        end
        @(negedge clk_i);
        v_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(negedge clk_i); n++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    // Behavioural multiplier: accepts one op, answers after 0..3 extra cycles.
    initial begin
        mul_v_i = 1'b0; mul_ready_and_i = 1'b0; mul_result_i = '0;
        forever begin
            @(negedge clk_i);
            if (!manual) begin
                if (!reset_n_i) begin
                    mdl_busy = 1'b0; mul_v_i = 1'b0; mul_ready_and_i = 1'b0;
                end else begin
                    if (mdl_busy && mdl_lat == 0) begin
                        mul_v_i = 1'b1; mul_result_i = mdl_res;
                    end else begin
                        mul_v_i = 1'b0;
                        if (mdl_busy) mdl_lat--;
                    end
                    mul_ready_and_i = !mdl_busy && ($urandom_range(0, 3) != 0);
                    #1;
                    if (mul_v_i) begin
                        check("mul_yumi", mul_yumi_o, 1);
                        if (mul_yumi_o) mdl_busy = 1'b0;
                    end
                    if (mul_ready_and_i && mul_v_o) begin
                        if (iss_q.size() == 0) begin
                            check("issue_unexpected", {mul_opA_o, mul_opB_o}, 0);
                        end else begin
                            iss_t e;
                            e = iss_q.pop_front();
                            check("issue_opA", mul_opA_o, e.a);
                            check("issue_opB", mul_opB_o, e.b);
                            check("issue_ctrl", {mul_signed_opA_o, mul_signed_opB_o, mul_gets_high_part_o}, e.ctrl);
                        end
                        mdl_res  = hw_mul(mul_opA_o, mul_opB_o, mul_signed_opA_o, mul_signed_opB_o, mul_gets_high_part_o);
                        mdl_busy = 1'b1;
                        mdl_lat  = $urandom_range(0, 3);
                    end
                end
            end
        end
    end

    // Result monitor: pops the scoreboard on every v_o & yumi_i handshake.
    initial begin
        logic        prev_v = 1'b0, prev_yumi = 1'b0;
        logic [31:0] prev_res = '0;
        logic [3:0]  prev_tag = '0;
        yumi_i = 1'b0;
        forever begin
            @(negedge clk_i);
            yumi_i = (yumi_mode == 1) ? 1'b1 : (yumi_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (reset_n_i && v_o) begin
                check("v_mul_v_exclusive", mul_v_o, 0);
                if (prev_v && !prev_yumi) begin
                    check("hold_result", result_o, prev_res);
                    check("hold_tag", tag_o, prev_tag);
                end
                if (yumi_i) begin
                    if (sb_q.size() == 0) begin
                        check("result_unexpected", {result_o, tag_o}, 0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("result", result_o, e.res);
                        check("tag", tag_o, e.tag);
                    end
                end
            end
            prev_v = reset_n_i && v_o; prev_yumi = yumi_i;
            prev_res = result_o; prev_tag = tag_o;
        end
    end

    initial begin
        logic [31:0] a, b;
        reset_n_i = 1'b0; v_i = 1'b0; funct_i = '0; opA_i = '0; opB_i = '0; tag_i = '0;
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        #2;
        check("reset_ready", ready_and_o, 1);
        check("reset_v_o", v_o, 0);
        check("reset_mul_v_o", mul_v_o, 0);
        check("reset_mul_yumi", mul_yumi_o, 0);
        check("reset_result_tag", {result_o, tag_o}, 0);
        @(negedge clk_i);

        // MUL low half and the three high-half flavours
        send(2'd0, 32'd7, 32'hFFFF_FFFD, 4'd5);
        drain();
        send(2'd1, 32'h8000_0000, 32'h8000_0000, 4'd1);
        send(2'd2, 32'hFFFF_FFFF, 32'd2, 4'd2);
        send(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3);
        drain();

        // Zero bypass latency, then a held result with yumi_i low
        yumi_mode = 0;
        send(2'd3, 32'd0, 32'h1234, 4'd2);
        #2;
        check("bypass_t1_v_o", v_o, 0);
        check("bypass_mul_v_o", mul_v_o, 0);
        @(negedge clk_i); #2;
        check("bypass_t2_v_o", v_o, 1);
        check("bypass_result_tag", {result_o, tag_o}, {32'd0, 4'd2});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i); #2;
            check("held_v_o", v_o, 1);
            check("held_result_tag", {result_o, tag_o}, {32'd0, 4'd2});
            check("held_no_issue", mul_v_o, 0);
        end
        yumi_mode = 1;
        @(negedge clk_i);
        drain();

        // Five back-to-back requests with the result port stalled
        yumi_mode = 0;
        for (int t = 0; t < 5; t++) begin
            a = $urandom; if (a == 0) a = 32'd1;
            b = $urandom; if (b == 0) b = 32'd3;
            send(2'($urandom_range(0, 3)), a, b, 4'(t));
        end
        repeat (3) @(negedge clk_i);
        #2;
        check("full_ready_low", ready_and_o, 0);
        check("full_v_o", v_o, 1);
        yumi_mode = 1;
        @(negedge clk_i);
        drain();

        // Reset while BUSY drops the in-flight op; stray mul_v_i afterwards is ignored
        manual = 1'b1;
        mul_ready_and_i = 1'b1; mul_v_i = 1'b0;
        send(2'd0, 32'd3, 32'd4, 4'd9);
        @(negedge clk_i); #2;
        check("t6_busy_no_issue", mul_v_o, 0);
        check("t6_busy_v_o", v_o, 0);
        reset_n_i = 1'b0; mul_ready_and_i = 1'b0;
        @(negedge clk_i);
        sb_q.delete(); iss_q.delete();
        reset_n_i = 1'b1;
        #2;
        check("t6_v_o", v_o, 0);
        check("t6_ready", ready_and_o, 1);
        check("t6_mul_v_o", mul_v_o, 0);
        mul_v_i = 1'b1; mul_result_i = 32'hDEAD_BEEF;
        #1;
        check("t6_stray_yumi", mul_yumi_o, 0);
        @(negedge clk_i); #2;
        check("t6_stray_yumi2", mul_yumi_o, 0);
        check("t6_v_o2", v_o, 0);
        mul_v_i = 1'b0; mdl_busy = 1'b0; manual = 1'b0;
        @(negedge clk_i);

        // Randomised traffic with zero operands, idle gaps and random consumption
        yumi_mode = 2;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            send(2'($urandom_range(0, 3)), a, b, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk_i);
        end
        yumi_mode = 1;
        drain();
        check("issue_queue_empty", iss_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
